xadac_arb: RTL and testbench

Round-robin arbiter that merges `NoSlv` requester ports (issue/decode front-ends) onto one shared xadac master port, typically the slave port of the xadac instruction demux. It arbitrates the dec and exe request channels independently. An ID ownership table routes dec and exe responses back to the requester that issued each ID. The table also blocks ID collisions between requesters while an ID is in flight.

---
 rtl/xadac_arb_pkg.sv | 17 +
 rtl/xadac_arb_rr.sv | 42 ++++
 rtl/xadac_arb.sv | 92 +++++++++
 tb/tb_xadac_arb.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xadac_arb_pkg.sv
// xadac_arb_pkg: shared xadac payload types, scoreboard depth and index-width helper
package xadac_arb_pkg;
  localparam int SbLen = 8;
  localparam int IdW = $clog2(SbLen);
  typedef logic [IdW-1:0] IdT;
  typedef struct packed { IdT id; logic [31:0] instr; } DecReqT;
  typedef struct packed { IdT id; logic [3:0] flags; } DecRspT;
  typedef struct packed { IdT id; logic [31:0] data; } ExeReqT;
  typedef struct packed { IdT id; logic [31:0] rd; } ExeRspT;
  localparam int DecReqW = $bits(DecReqT);
  localparam int DecRspW = $bits(DecRspT);
  localparam int ExeReqW = $bits(ExeReqT);
  localparam int ExeRspW = $bits(ExeRspT);
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/xadac_arb_rr.sv
// xadac_rr_arb: round-robin grant that holds its choice while the downstream stalls
module xadac_rr_arb import xadac_arb_pkg::*; #(
  parameter int N = 2,
  localparam int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  elig,
  input  logic          lock,
  input  logic          hs,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] ptr_q, hold_q, pick, c;
  logic lock_q, found;
  always_comb begin
    pick = ptr_q;
    found = 1'b0;
    c = ptr_q;
    for (int k = 0; k < N; k++) begin
      if (!found && elig[c]) begin
        pick = c;
        found = 1'b1;
      end
      c = (c == IW'(N - 1)) ? '0 : c + 1'b1;
    end
    idx = lock_q ? hold_q : pick;
    gnt = (lock_q ? elig[hold_q] : found) ? {{(N-1){1'b0}}, 1'b1} << idx : '0;
  end
  // a stalled grant is remembered in hold_q so valid/payload stay put until the handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
      hold_q <= '0;
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock;
      hold_q <= idx;
      if (hs) ptr_q <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: rtl/xadac_arb.sv
// xadac_arb: merges NoSlv xadac requesters onto one master port, routing responses by ID owner
module xadac_arb import xadac_arb_pkg::*; #(
  parameter int NoSlv = 2,
  localparam int IW = idx_w(NoSlv)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NoSlv-1:0]                slv_dec_req_valid,
  output logic [NoSlv-1:0]                slv_dec_req_ready,
  input  logic [NoSlv-1:0][DecReqW-1:0]   slv_dec_req,
  output logic [NoSlv-1:0]                slv_dec_rsp_valid,
  input  logic [NoSlv-1:0]                slv_dec_rsp_ready,
  output logic [NoSlv-1:0][DecRspW-1:0]   slv_dec_rsp,
  input  logic [NoSlv-1:0]                slv_exe_req_valid,
  output logic [NoSlv-1:0]                slv_exe_req_ready,
  input  logic [NoSlv-1:0][ExeReqW-1:0]   slv_exe_req,
  output logic [NoSlv-1:0]                slv_exe_rsp_valid,
  input  logic [NoSlv-1:0]                slv_exe_rsp_ready,
  output logic [NoSlv-1:0][ExeRspW-1:0]   slv_exe_rsp,
  output logic                            mst_dec_req_valid,
  input  logic                            mst_dec_req_ready,
  output logic [DecReqW-1:0]              mst_dec_req,
  input  logic                            mst_dec_rsp_valid,
  output logic                            mst_dec_rsp_ready,
  input  logic [DecRspW-1:0]              mst_dec_rsp,
  output logic                            mst_exe_req_valid,
  input  logic                            mst_exe_req_ready,
  output logic [ExeReqW-1:0]              mst_exe_req,
  input  logic                            mst_exe_rsp_valid,
  output logic                            mst_exe_rsp_ready,
  input  logic [ExeRspW-1:0]              mst_exe_rsp
);
  logic [SbLen-1:0] busy_q, busy_d;
  logic [SbLen-1:0][IW-1:0] owner_q, owner_d;
  logic [NoSlv-1:0] dec_elig, exe_elig, dec_gnt, exe_gnt;
  logic [IW-1:0] dec_idx, exe_idx, dec_own, exe_own;
  logic dec_hs, exe_rsp_hs;
  IdT dec_id, drsp_id, ersp_id;
  assign dec_id = mst_dec_req[DecReqW-1 -: IdW];
  assign drsp_id = mst_dec_rsp[DecRspW-1 -: IdW];
  assign ersp_id = mst_exe_rsp[ExeRspW-1 -: IdW];
  assign dec_own = owner_q[drsp_id];
  assign exe_own = owner_q[ersp_id];
  for (genvar i = 0; i < NoSlv; i++) begin : g_slv
    assign dec_elig[i] = slv_dec_req_valid[i] && !busy_q[slv_dec_req[i][DecReqW-1 -: IdW]];
    assign exe_elig[i] = slv_exe_req_valid[i] && busy_q[slv_exe_req[i][ExeReqW-1 -: IdW]] &&
                         owner_q[slv_exe_req[i][ExeReqW-1 -: IdW]] == IW'(i);
    assign slv_dec_rsp_valid[i] = mst_dec_rsp_valid && dec_own == IW'(i);
    assign slv_exe_rsp_valid[i] = mst_exe_rsp_valid && exe_own == IW'(i);
    assign slv_dec_rsp[i] = slv_dec_rsp_valid[i] ? mst_dec_rsp : '0;
    assign slv_exe_rsp[i] = slv_exe_rsp_valid[i] ? mst_exe_rsp : '0;
  end
  xadac_rr_arb #(.N(NoSlv)) u_dec_arb (
    .clk(clk), .rstn(rstn), .elig(dec_elig),
    .lock(mst_dec_req_valid && !mst_dec_req_ready), .hs(dec_hs),
    .gnt(dec_gnt), .idx(dec_idx)
  );
  xadac_rr_arb #(.N(NoSlv)) u_exe_arb (
    .clk(clk), .rstn(rstn), .elig(exe_elig),
    .lock(mst_exe_req_valid && !mst_exe_req_ready), .hs(mst_exe_req_valid && mst_exe_req_ready),
    .gnt(exe_gnt), .idx(exe_idx)
  );
  assign mst_dec_req_valid = |dec_gnt;
  assign mst_exe_req_valid = |exe_gnt;
  assign mst_dec_req = mst_dec_req_valid ? slv_dec_req[dec_idx] : '0;
  assign mst_exe_req = mst_exe_req_valid ? slv_exe_req[exe_idx] : '0;
  assign slv_dec_req_ready = mst_dec_req_ready ? dec_gnt : '0;
  assign slv_exe_req_ready = mst_exe_req_ready ? exe_gnt : '0;
  assign mst_dec_rsp_ready = mst_dec_rsp_valid && slv_dec_rsp_ready[dec_own];
  assign mst_exe_rsp_ready = mst_exe_rsp_valid && slv_exe_rsp_ready[exe_own];
  assign dec_hs = mst_dec_req_valid && mst_dec_req_ready;
  assign exe_rsp_hs = mst_exe_rsp_valid && mst_exe_rsp_ready;
  // an ID is claimed by dec_req and released by exe_rsp
  always_comb begin
    busy_d = busy_q;
    owner_d = owner_q;
    if (exe_rsp_hs) busy_d[ersp_id] = 1'b0;
    if (dec_hs) begin
      busy_d[dec_id] = 1'b1;
      owner_d[dec_id] = dec_idx;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
      owner_q <= '0;
    end else begin
      busy_q <= busy_d;
      owner_q <= owner_d;
    end
  end
endmodule

// File: tb/tb_xadac_arb.sv
// tb_xadac_arb: vector table and scoreboard checks of the xadac request arbiter
module tb_xadac_arb;
  import xadac_arb_pkg::*;
  localparam int N = 2;
  logic clk = 1'b0;
  logic rstn;
  logic [N-1:0] slv_dec_req_valid, slv_dec_req_ready, slv_dec_rsp_valid, slv_dec_rsp_ready;
  logic [N-1:0] slv_exe_req_valid, slv_exe_req_ready, slv_exe_rsp_valid, slv_exe_rsp_ready;
  logic [N-1:0][DecReqW-1:0] slv_dec_req;
  logic [N-1:0][DecRspW-1:0] slv_dec_rsp;
  logic [N-1:0][ExeReqW-1:0] slv_exe_req;
  logic [N-1:0][ExeRspW-1:0] slv_exe_rsp;
  logic mst_dec_req_valid, mst_dec_req_ready, mst_dec_rsp_valid, mst_dec_rsp_ready;
  logic mst_exe_req_valid, mst_exe_req_ready, mst_exe_rsp_valid, mst_exe_rsp_ready;
  logic [DecReqW-1:0] mst_dec_req;
  logic [DecRspW-1:0] mst_dec_rsp;
  logic [ExeReqW-1:0] mst_exe_req;
  logic [ExeRspW-1:0] mst_exe_rsp;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct { int src; int id; } exp_t;
  exp_t sb[$];
  exp_t e;
  typedef struct { logic is_exe; IdT id; logic [1:0] srdy; logic [1:0] exp_vld; logic exp_mrdy; } rsp_vec_t;
  rsp_vec_t tv[16];
  int j, n0, n1, o;
  logic [N-1:0] h;

  always #5 clk = ~clk;

  xadac_arb #(.NoSlv(N)) dut (
    .clk(clk), .rstn(rstn),
    .slv_dec_req_valid(slv_dec_req_valid), .slv_dec_req_ready(slv_dec_req_ready), .slv_dec_req(slv_dec_req),
    .slv_dec_rsp_valid(slv_dec_rsp_valid), .slv_dec_rsp_ready(slv_dec_rsp_ready), .slv_dec_rsp(slv_dec_rsp),
    .slv_exe_req_valid(slv_exe_req_valid), .slv_exe_req_ready(slv_exe_req_ready), .slv_exe_req(slv_exe_req),
    .slv_exe_rsp_valid(slv_exe_rsp_valid), .slv_exe_rsp_ready(slv_exe_rsp_ready), .slv_exe_rsp(slv_exe_rsp),
    .mst_dec_req_valid(mst_dec_req_valid), .mst_dec_req_ready(mst_dec_req_ready), .mst_dec_req(mst_dec_req),
    .mst_dec_rsp_valid(mst_dec_rsp_valid), .mst_dec_rsp_ready(mst_dec_rsp_ready), .mst_dec_rsp(mst_dec_rsp),
    .mst_exe_req_valid(mst_exe_req_valid), .mst_exe_req_ready(mst_exe_req_ready), .mst_exe_req(mst_exe_req),
    .mst_exe_rsp_valid(mst_exe_rsp_valid), .mst_exe_rsp_ready(mst_exe_rsp_ready), .mst_exe_rsp(mst_exe_rsp)
  );

  function automatic DecReqT mk_dec(input IdT id);
    DecReqT r;
    r.id = id;
    r.instr = 32'h1000_0000 + 32'(id);
    return r;
  endfunction
  function automatic ExeReqT mk_exe(input IdT id, input logic [31:0] d);
    ExeReqT r;
    r.id = id;
    r.data = d;
    return r;
  endfunction
  function automatic DecRspT mk_drsp(input IdT id);
    DecRspT r;
    r.id = id;
    r.flags = {1'b1, id};
    return r;
  endfunction
  function automatic ExeRspT mk_ersp(input IdT id);
    ExeRspT r;
    r.id = id;
    r.rd = 32'hE000_0000 + 32'(id);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    slv_dec_req_valid = '0; slv_dec_req = '0; slv_dec_rsp_ready = '0;
    slv_exe_req_valid = '0; slv_exe_req = '0; slv_exe_rsp_ready = '0;
    mst_dec_req_ready = 1'b0; mst_dec_rsp_valid = 1'b0; mst_dec_rsp = '0;
    mst_exe_req_ready = 1'b0; mst_exe_rsp_valid = 1'b0; mst_exe_rsp = '0;
  endtask
  task automatic chk_idle(input string t);
    chk({t, "_mst_vld"}, {mst_dec_req_valid, mst_exe_req_valid}, 0);
    chk({t, "_rdy"}, {slv_dec_req_ready, slv_exe_req_ready, mst_dec_rsp_ready, mst_exe_rsp_ready}, 0);
    chk({t, "_slv_vld"}, {slv_dec_rsp_valid, slv_exe_rsp_valid}, 0);
    chk({t, "_payload"}, {|mst_dec_req, |mst_exe_req, |slv_dec_rsp, |slv_exe_rsp}, 0);
  endtask

  initial begin
    // response routing vectors; owners follow the contention pattern (odd IDs belong to slv1)
    for (int k = 0; k < 8; k++) tv[k] = '{1'b0, IdT'(k), 2'b11, (k % 2 == 1) ? 2'b10 : 2'b01, 1'b1};
    tv[8] = '{1'b0, IdT'(3), 2'b01, 2'b10, 1'b0};
    j = 9;
    for (int k = 0; k < 8; k++) if (k != 4) begin
      tv[j] = '{1'b1, IdT'(k), 2'b11, (k % 2 == 1) ? 2'b10 : 2'b01, 1'b1};
      j++;
    end
    clr();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("rst_hold");
    rstn = 1'b1;
    #1;
    chk_idle("post_rst");
    tick();
    // contention: grants must alternate starting with slv0
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{0, 2 * k});
      sb.push_back('{1, 2 * k + 1});
    end
    n0 = 0;
    n1 = 0;
    mst_dec_req_ready = 1'b1;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      slv_dec_req_valid = {n1 < 4, n0 < 4};
      slv_dec_req[0] = mk_dec(IdT'(2 * n0));
      slv_dec_req[1] = mk_dec(IdT'(2 * n1 + 1));
      #1;
      h = slv_dec_req_ready;
      if (mst_dec_req_valid && mst_dec_req_ready) begin
        e = sb.pop_front();
        chk("cont_src", slv_dec_req_ready, (e.src == 0) ? 2'b01 : 2'b10);
        chk("cont_req", mst_dec_req, mk_dec(IdT'(e.id)));
      end
      tick();
      if (h[0]) n0++;
      if (h[1]) n1++;
    end
    chk("cont_drain", sb.size(), 0);
    slv_dec_req_valid = 2'b11;
    slv_dec_req[0] = mk_dec(0);
    slv_dec_req[1] = mk_dec(1);
    #1;
    chk("full_block", {mst_dec_req_valid, slv_dec_req_ready}, 0);
    tick();
    // foreign exe_req: slv1 may not use slv0's ID 2
    clr();
    mst_exe_req_ready = 1'b1;
    slv_exe_req_valid = 2'b11;
    slv_exe_req[0] = mk_exe(2, 32'hAAAA_0000);
    slv_exe_req[1] = mk_exe(2, 32'hBBBB_0000);
    #1;
    chk("foreign_gnt", {mst_exe_req_valid, slv_exe_req_ready}, 3'b101);
    chk("foreign_req", mst_exe_req, mk_exe(2, 32'hAAAA_0000));
    tick();
    slv_exe_req_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("foreign_stall", {mst_exe_req_valid, slv_exe_req_ready}, 0);
      tick();
    end
    slv_exe_req_valid = 2'b11;
    slv_exe_req[0] = mk_exe(0, 32'hAAAA_0001);
    slv_exe_req[1] = mk_exe(3, 32'hBBBB_0001);
    #1;
    chk("exe_rr_1", slv_exe_req_ready, 2'b10);
    chk("exe_rr_1_req", mst_exe_req, mk_exe(3, 32'hBBBB_0001));
    tick();
    slv_exe_req_valid = 2'b01;
    #1;
    chk("exe_rr_0", slv_exe_req_ready, 2'b01);
    tick();
    // response routing vectors, applied while the table is still full
    clr();
    for (int k = 0; k < 16; k++) begin
      mst_dec_rsp_valid = !tv[k].is_exe;
      mst_exe_rsp_valid = tv[k].is_exe;
      mst_dec_rsp = mk_drsp(tv[k].id);
      mst_exe_rsp = mk_ersp(tv[k].id);
      slv_dec_rsp_ready = tv[k].srdy;
      slv_exe_rsp_ready = tv[k].srdy;
      o = tv[k].exp_vld[1] ? 1 : 0;
      #1;
      if (tv[k].is_exe) begin
        chk("exe_rsp_vld", {slv_exe_rsp_valid, slv_dec_rsp_valid}, {tv[k].exp_vld, 2'b00});
        chk("exe_rsp_mrdy", mst_exe_rsp_ready, tv[k].exp_mrdy);
        chk("exe_rsp_data", slv_exe_rsp[o], mk_ersp(tv[k].id));
      end else begin
        chk("dec_rsp_vld", {slv_dec_rsp_valid, slv_exe_rsp_valid}, {tv[k].exp_vld, 2'b00});
        chk("dec_rsp_mrdy", mst_dec_rsp_ready, tv[k].exp_mrdy);
        chk("dec_rsp_data", slv_dec_rsp[o], mk_drsp(tv[k].id));
      end
      tick();
    end
    // ID collision: slv0 still holds ID 4
    clr();
    slv_dec_req_valid = 2'b10;
    slv_dec_req[1] = mk_dec(4);
    mst_dec_req_ready = 1'b1;
    #1;
    chk("coll_block", {mst_dec_req_valid, slv_dec_req_ready}, 0);
    tick();
    mst_exe_rsp_valid = 1'b1;
    mst_exe_rsp = mk_ersp(4);
    slv_exe_rsp_ready = 2'b11;
    #1;
    chk("coll_same_cyc", {mst_dec_req_valid, slv_dec_req_ready}, 0);
    chk("coll_rsp_route", {slv_exe_rsp_valid, mst_exe_rsp_ready}, 3'b011);
    tick();
    mst_exe_rsp_valid = 1'b0;
    #1;
    chk("coll_grant", slv_dec_req_ready, 2'b10);
    chk("coll_id", mst_dec_req, mk_dec(4));
    tick();
    // stall lock: slv1 joins while slv0's ID 5 is stalled and the pointer favours slv1
    clr();
    slv_dec_req_valid = 2'b01;
    slv_dec_req[0] = mk_dec(0);
    mst_dec_req_ready = 1'b1;
    #1;
    chk("pre_lock_gnt", slv_dec_req_ready, 2'b01);
    tick();
    slv_dec_req[0] = mk_dec(5);
    mst_dec_req_ready = 1'b0;
    #1;
    chk("lock_c0", mst_dec_req, mk_dec(5));
    chk("lock_c0_v", {mst_dec_req_valid, slv_dec_req_ready}, 3'b100);
    tick();
    slv_dec_req_valid = 2'b11;
    slv_dec_req[1] = mk_dec(6);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("lock_hold", mst_dec_req, mk_dec(5));
      chk("lock_hold_v", {mst_dec_req_valid, slv_dec_req_ready}, 3'b100);
      tick();
    end
    mst_dec_req_ready = 1'b1;
    #1;
    chk("lock_hs", slv_dec_req_ready, 2'b01);
    chk("lock_hs_id", mst_dec_req, mk_dec(5));
    tick();
    slv_dec_req_valid = 2'b10;
    #1;
    chk("lock_next", slv_dec_req_ready, 2'b10);
    chk("lock_next_id", mst_dec_req, mk_dec(6));
    tick();
    slv_dec_req[1] = mk_dec(3);
    #1;
    chk("id3_gnt", slv_dec_req_ready, 2'b10);
    tick();
    // reset in the middle of traffic, with ID 3 in flight
    slv_dec_req_valid = 2'b11;
    slv_dec_req[0] = mk_dec(1);
    mst_dec_req_ready = 1'b0;
    mst_exe_rsp_valid = 1'b1;
    mst_exe_rsp = mk_ersp(0);
    slv_exe_rsp_ready = 2'b01;
    #1;
    chk("mid_traffic", {mst_dec_req_valid, slv_exe_rsp_valid}, 3'b101);
    #2;
    rstn = 1'b0;
    clr();
    #1;
    chk_idle("rst_mid");
    tick();
    tick();
    rstn = 1'b1;
    slv_dec_req_valid = 2'b10;
    slv_dec_req[1] = mk_dec(3);
    mst_dec_req_ready = 1'b1;
    #1;
    chk("post_rst_gnt", slv_dec_req_ready, 2'b10);
    chk("post_rst_id", mst_dec_req, mk_dec(3));
    tick();
    clr();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
